// File: rtl/uart_frame_gen.sv
// uart_frame_gen -- parametrised UART frame generator.
//
// Bytes are queued in a small FIFO through a valid/ready push port and sent
// on serial_tx as UART frames: one start bit, DATA_BITS data bits (LSB first),
// an optional parity bit, STOP_BITS stop bits and GAP_BITS idle bit periods.
// Every bit lasts BAUD_DIV system clocks.
//
// Optional feature: define UART_FRAME_GEN_REPEAT_EN to enable repeat_mode.
// Each popped word is then written back at the FIFO tail, so the queued
// sequence replays for as long as enable stays high.
//
// Ports:
//   clock        system clock, all logic on the rising edge
//   reset        asynchronous, active-low reset
//   enable       permits new frames to start
//   wr_valid     push request
//   wr_data      frame payload (DATA_BITS wide)
//   wr_ready     FIFO can accept; a push happens on wr_valid & wr_ready
//   repeat_mode  recirculate FIFO contents (ignored unless the macro is set)
//   serial_tx    UART line, idle high
//   busy         high in every state except IDLE
//   frame_done   one-cycle pulse on the final clock of the last stop bit
//   fifo_count   number of FIFO entries held
module uart_frame_gen #(
   parameter int BAUD_DIV  = 16,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int GAP_BITS  = 1,
   parameter int FIFO_LOG2 = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 wr_valid,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic                 wr_ready,
   input  logic                 repeat_mode,
   output logic                 serial_tx,
   output logic                 busy,
   output logic                 frame_done,
   output logic [FIFO_LOG2:0]   fifo_count
);

   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int CNT_W = $clog2(BAUD_DIV);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_GAP    = 3'd5;

   logic [2:0]           state;
   logic [CNT_W-1:0]     baud_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr;
   logic [FIFO_LOG2-1:0] rd_ptr;
   logic                 push;
   logic                 pop;
   logic                 recirc;
   logic                 baud_end;
   logic                 fifo_full;

   assign fifo_full = (fifo_count == (FIFO_LOG2+1)'(DEPTH));
   assign baud_end  = (baud_cnt == CNT_W'(BAUD_DIV - 1));
   assign pop       = (state == S_IDLE) && enable && (fifo_count != '0);

`ifdef UART_FRAME_GEN_REPEAT_EN
   // Recirculation reuses the tail write port, so external pushes are
   // blocked while repeat_mode is high.
   assign recirc   = pop && repeat_mode;
   assign wr_ready = !fifo_full && !repeat_mode;
`else
   logic unused_repeat;
   assign unused_repeat = repeat_mode;
   assign recirc        = 1'b0;
   assign wr_ready      = !fifo_full;
`endif

   assign push       = wr_valid && wr_ready;
   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_STOP) && (bit_cnt == 4'(STOP_BITS - 1)) && baud_end;

   // FIFO pointers and occupancy
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push || recirc)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         // A recirculating pop writes the word back, so the count holds.
         if (push && !pop)
            fifo_count <= fifo_count + 1'b1;
         else if (pop && !push && !recirc)
            fifo_count <= fifo_count - 1'b1;
      end
   end

   // FIFO storage and frame payload (data only, no reset)
   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= wr_data;
      else if (recirc)
         mem[wr_ptr] <= mem[rd_ptr];
      if (pop) begin
         shreg   <= mem[rd_ptr];
         par_bit <= (PARITY == 2) ? ~(^mem[rd_ptr]) : ^mem[rd_ptr];
      end else if (baud_end && ((state == S_START) || (state == S_DATA))) begin
         // serial_tx takes shreg[0] at this edge; expose the next bit.
         shreg <= shreg >> 1;
      end
   end

   // Frame sequencer; serial_tx is registered so the line is glitch-free.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         serial_tx <= 1'b1;
      end else if (state == S_IDLE) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         if (pop) begin
            state     <= S_START;
            serial_tx <= 1'b0;
         end
      end else begin
         baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
         if (baud_end) begin
            case (state)
               S_START: begin
                  state     <= S_DATA;
                  bit_cnt   <= '0;
                  serial_tx <= shreg[0];
               end
               S_DATA: begin
                  if (bit_cnt == 4'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     if (PARITY != 0) begin
                        state     <= S_PARITY;
                        serial_tx <= par_bit;
                     end else begin
                        state     <= S_STOP;
                        serial_tx <= 1'b1;
                     end
                  end else begin
                     bit_cnt   <= bit_cnt + 1'b1;
                     serial_tx <= shreg[0];
                  end
               end
               S_PARITY: begin
                  state     <= S_STOP;
                  bit_cnt   <= '0;
                  serial_tx <= 1'b1;
               end
               S_STOP: begin
                  serial_tx <= 1'b1;
                  if (bit_cnt == 4'(STOP_BITS - 1)) begin
                     bit_cnt <= '0;
                     state   <= (GAP_BITS > 0) ? S_GAP : S_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               S_GAP: begin
                  serial_tx <= 1'b1;
                  if (bit_cnt == 4'(GAP_BITS - 1)) begin
                     bit_cnt <= '0;
                     state   <= S_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: begin
                  state     <= S_IDLE;
                  serial_tx <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/uart_frame_gen.md
Name: uart_frame_gen

Overview:
Parametrised UART frame generator for bench and on-chip stimulus. Drives the core's serial_rx input with configurable frames: data width, parity, stop bits and inter-frame gap are parameters. Bytes are queued through a small FIFO with a valid/ready push port. Baud timing comes from an internal divider on the system clock.

Parameters:
BAUD_DIV, 16, system clocks per bit period (>=2)
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)
GAP_BITS, 1, idle-high bit periods after each frame (0..15)
FIFO_LOG2, 2, FIFO depth = 2**FIFO_LOG2 entries

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  permits new frames to start
wr_valid  input  1  push request
wr_data  input  DATA_BITS  frame payload
wr_ready  output  1  FIFO can accept; push occurs when wr_valid & wr_ready
repeat_mode  input  1  recirculate FIFO contents (optional feature)
serial_tx  output  1  UART line, idle high
busy  output  1  high in any state except IDLE
frame_done  output  1  one-cycle pulse at the end of the last stop bit
fifo_count  output  FIFO_LOG2+1  entries held

Behaviour:
- Reset (reset=0, async):
  - serial_tx=1, busy=0, frame_done=0, fifo_count=0, wr_ready=1
  - FIFO pointers 0; state IDLE; baud counter 0.
  - A frame in progress is abandoned; the line returns high immediately.
- wr_ready = (fifo_count != 2**FIFO_LOG2), from the registered count.
  - Push while full is ignored.
  - Push into an empty FIFO is visible to IDLE on the next cycle.
  - Push and pop in the same cycle leave the count unchanged.
- States: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE: if enable=1 and fifo_count!=0, pop the head into the shift register, compute the parity bit, load baud counter 0 and go to START.
  - serial_tx goes low on the same edge, so the line is low the first cycle after the pop edge.
- Bit timing:
  - Each bit lasts exactly BAUD_DIV clocks; the counter runs 0..BAUD_DIV-1.
  - At terminal count: advance bit or state, counter returns to 0.
- START: line 0 for one bit, then DATA.
- DATA: DATA_BITS bits, LSB first.
  - Then PARITY if PARITY!=0, else STOP.
- PARITY: even gives XOR of the data bits; odd gives its inverse.
- STOP: line 1 for STOP_BITS bit periods.
  - frame_done is asserted for the final clock of the last stop bit.
  - Next state is GAP if GAP_BITS>0, else IDLE.
- GAP: line 1 for GAP_BITS periods, then IDLE.
- Frame-to-frame: the next START may begin the cycle after returning to IDLE, so the minimum idle between frames is GAP_BITS*BAUD_DIV+1 clocks.
- enable deasserted mid-frame: the current frame, including its gap, completes; no new frame starts.
- Changes to wr_data or wr_valid have no effect on a frame in flight.

Optional Feature:
- Macro UART_FRAME_GEN_REPEAT_EN.
- Defined:
  - When repeat_mode=1 at pop time, the popped word is re-pushed at the tail on the same edge, so fifo_count is unchanged.
  - The queued sequence replays indefinitely while enable=1.
  - wr_ready is forced 0 while repeat_mode=1.
  - Clearing repeat_mode lets the queue drain normally from the current head.
- Undefined: repeat_mode is ignored and every pop consumes its entry.

Test Plan:
- Basic frame: defaults with BAUD_DIV=4; push 0x42, enable=1.
  - Line: 0 for 4 clocks, then bits 0,1,0,0,0,0,1,0 at 4 clocks each, then 1.
  - frame_done on the 40th clock after the start edge; then 4 gap clocks.
- Parity: PARITY=1, push 0x0D (three ones) → parity bit 1.
  - PARITY=2 → 0. Frame length 44 clocks.
- Back-pressure: FIFO_LOG2=2, enable=0, push 5 words.
  - wr_ready drops after the 4th; the 5th is not stored.
  - fifo_count=4; enable=1 sends exactly 4 frames in order.
- Reset mid-frame: pull reset low during DATA bit 3.
  - serial_tx=1 and busy=0 with no clock edge.
  - After release, no frame until a new push.
- Enable drop: clear enable during the first frame with 2 words queued.
  - The first frame completes with frame_done.
  - The second does not start until enable=1.
- Repeat (macro on): queue 0x42, 0x0D; repeat_mode=1.
  - Line repeats 0x42, 0x0D, 0x42, 0x0D…; fifo_count stays 2; wr_ready=0.
